// File: rtl/data_memory_pkg.sv
// Shared types for the data memory: response pipeline stage and latency bound.
package data_memory_pkg;
  localparam int READ_LATENCY_MAX = 4;
  localparam int RSP_DATA_MAX     = 1024;

  // rdata is sized for the widest supported word; each instance truncates to DATA_WIDTH.
  typedef struct packed {
    logic                    valid;
    logic                    err;
    logic [RSP_DATA_MAX-1:0] rdata;
  } rsp_stage_t;
endpackage

// File: rtl/data_memory_array.sv
// Storage array with per-byte write enables and combinational read; no reset.
module data_memory_array
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256
) (
  input  logic                       clk,
  input  logic [$clog2(DEPTH)-1:0]   word_idx,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH/8-1:0]    wr_be,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic [DATA_WIDTH-1:0]      rd_data
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < DATA_WIDTH/8; k++) begin
        if (wr_be[k]) mem[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  assign rd_data = mem[word_idx];
endmodule

// File: rtl/data_memory.sv
// Data memory with valid/ready request/response and READ_LATENCY-stage response pipeline.
// DATA_MEMORY_ERR_EN enables misaligned/out-of-range error responses.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [31:0]             req_addr_i,
  input  logic                    req_we_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_be_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o
);
  localparam int OFF_W = $clog2(DATA_WIDTH/8);
  localparam int IDX_W = $clog2(DEPTH);

  rsp_stage_t            stages [READ_LATENCY];
  logic [IDX_W-1:0]      word_idx;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  stall;
  logic                  accept;
  logic                  err;
  logic                  wr_en;

  assign stall       = stages[READ_LATENCY-1].valid && !rsp_ready_i;
  assign req_ready_o = !stall;
  assign accept      = req_valid_i && req_ready_o && !rst;
  assign word_idx    = IDX_W'(req_addr_i >> OFF_W);

`ifdef DATA_MEMORY_ERR_EN
  localparam logic [31:0] OFF_MASK = 32'((64'd1 << OFF_W) - 64'd1);
  assign err = ((req_addr_i & OFF_MASK) != 32'd0) ||
               ((req_addr_i >> (OFF_W + IDX_W)) != 32'd0);
`else
  assign err = 1'b0;
`endif

  assign wr_en = accept && req_we_i && !err;

  data_memory_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk      (clk),
    .word_idx (word_idx),
    .wr_en    (wr_en),
    .wr_be    (req_be_i),
    .wr_data  (req_wdata_i),
    .rd_data  (rd_data)
  );

  // Whole pipeline freezes together so in-flight responses keep their spacing under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) stages[i] <= '0;
    end else if (!stall) begin
      stages[0] <= '{valid: accept,
                     err:   accept && err,
                     rdata: (accept && !req_we_i && !err) ? RSP_DATA_MAX'(rd_data) : '0};
      for (int i = 1; i < READ_LATENCY; i++) stages[i] <= stages[i-1];
    end
  end

  assign rsp_valid_o = stages[READ_LATENCY-1].valid;
  assign rsp_err_o   = stages[READ_LATENCY-1].err;
  assign rsp_rdata_o = DATA_WIDTH'(stages[READ_LATENCY-1].rdata);
endmodule

// File: doc/data_memory.md
# data_memory

Parametrised single-port data memory with byte-addressed requests, per-byte write strobes, a valid/ready request and response handshake, and a configurable read-latency pipeline with backpressure. It is the core's data-side memory, replacing the fixed 256-word, zero-latency array. It sits between the load/store unit and the storage array, with every access, read or write, producing exactly one response.

## Interface
- DATA_WIDTH, 32: word width in bits; multiple of 8, at least 8.
- DEPTH, 256: number of words; power of two, at least 2.
- READ_LATENCY, 1: cycles from request acceptance to response valid; range 1..4.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  request may be accepted this cycle.
- req_addr_i  input  32  byte address.
- req_we_i  input  1  1 = write, 0 = read.
- req_wdata_i  input  DATA_WIDTH  write data.
- req_be_i  input  DATA_WIDTH/8  byte enables; bit k covers bits 8k+7:8k.
- rsp_valid_o  output  1  response present.
- rsp_ready_i  input  1  consumer takes response.
- rsp_rdata_o  output  DATA_WIDTH  read data; 0 for write responses.
- rsp_err_o  output  1  access error; see Configuration.

## Operation
- Accept = req_valid_i && req_ready_o at a rising edge.
- Word index = req_addr_i >> log2(DATA_WIDTH/8). Only the low log2(DEPTH) bits select the word.
- Write accept:
  - Each byte with req_be_i set is updated at that edge. Other bytes are unchanged.
  - be = 0 is legal: no change, response still issued.
- Read accept: the array word is sampled at the accept edge into pipeline stage 1. The sample reflects every write accepted at earlier edges.
- Single port: exactly one access per cycle, so there is no read/write collision.
- Pipeline: READ_LATENCY stages, each holding valid, rdata and err. The last stage drives the rsp_* outputs.
- stall = rsp_valid_o && !rsp_ready_i.
  - While stall is 1, all stages hold their contents.
  - Otherwise all stages advance by one.
- req_ready_o = !stall. A request is never accepted while the pipeline is frozen. This is combinational from rsp_ready_i.
- Ordering: responses are returned strictly in acceptance order. No response is dropped or duplicated.
- Reset:
  - Clears all stage valids. rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
  - req_ready_o=1 after reset, once stall clears.
  - Array contents are not reset. Writes accepted before reset persist.
  - In-flight responses are discarded.
- rst and req_valid_i high in the same cycle: the request is not accepted and no write occurs.

## Timing
- Request accepted at edge N: rsp_valid_o is high in the cycle after edge N+READ_LATENCY-1. With READ_LATENCY=1, the response is valid in the cycle following acceptance.
- Throughput: one access per cycle with no bubbles while rsp_ready_i=1.
- Backpressure: rsp_ready_i low for K cycles delays every in-flight response by exactly K cycles.
- Read-after-write to the same word at consecutive edges returns the new data.
- rsp_rdata_o and rsp_err_o are stable while rsp_valid_o && !rsp_ready_i.

## Configuration
- Macro: DATA_MEMORY_ERR_EN.
- Defined:
  - Error = misaligned (address low log2(DATA_WIDTH/8) bits nonzero) OR out of range (address bits above the word-index field nonzero).
  - An erroneous write modifies nothing.
  - An erroneous read returns rsp_rdata_o=0.
  - Both report rsp_err_o=1 with normal latency and handshake.
- Undefined:
  - rsp_err_o is tied 0.
  - Low address bits are ignored.
  - Upper bits are ignored, so addresses wrap modulo DEPTH words.

## Structure
- Package data_memory_pkg: rsp_stage_t struct (valid, rdata, err) and the READ_LATENCY_MAX=4 constant. Parameter-dependent widths are derived locally.
- Sub-module data_memory_array: the storage array only, with clk, word index, write enable, byte enables, write data and combinational read data. It has no reset.
- Handshake, error check and response pipeline stay in data_memory.

## Test plan
- Reset, then write 0xDEADBEEF at address 0x10 with be=0xF, then read 0x10: write response has rdata 0 and err 0; read returns 0xDEADBEEF after READ_LATENCY cycles.
- Write 0x000000AA to address 0x20 with be=0x1 over an existing 0x11223344: subsequent read returns 0x112233AA.
- READ_LATENCY=3, back-to-back reads of addresses 0x0, 0x4, 0x8 with rsp_ready_i held low for 5 cycles mid-stream: req_ready_o low during the stall; responses arrive in order with data intact and no gaps once ready returns.
- With DATA_MEMORY_ERR_EN, write 0x55 to address 0x2, then to 0x400 (DEPTH=256): both responses have err=1; a read of 0x0 shows the original data unchanged. Without the macro, address 0x400 aliases word 0.
- Assert rst with 2 responses in flight: rsp_valid_o=0 the cycle after; memory written before reset still reads back its value.
- Write to address 0x8 accepted at edge N, read of 0x8 accepted at edge N+1: the read returns the new value.
